// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch stage plus IF/ID pipeline register.
// Keeps one instruction-memory request outstanding, absorbs decode stalls in a skid buffer, and redirects on flush.
module fetch_ifid #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [63:0] ifid_pc
);

  // REQ: request on addr_q. HOLD: skid full, waiting for decode.
  // DRAIN: a flushed request is still in flight and its reply must be dropped.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;

  logic        accept;
  logic        ack;
  logic        load_ifid;
  logic [31:0] load_instr;
  logic [63:0] load_pc;
  logic [63:0] drain_pc;

  assign accept = !ifid_valid_q || !stall;
  // An ack is only meaningful while a request is actually being presented.
  assign ack    = imem_ack && (state_q != S_HOLD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (flush && !ack)
          state_d = S_DRAIN;
        else if (ack && !flush && !accept)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush || !stall)
          state_d = S_REQ;
      end
      S_DRAIN: begin
        if (ack)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    addr_d       = addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load_ifid    = 1'b0;
    load_instr   = '0;
    load_pc      = '0;
    drain_pc     = flush ? branch_target : pc_q;

    unique case (state_q)
      S_REQ: begin
        if (ack) begin
          if (flush) begin
            pc_d   = branch_target;
            addr_d = branch_target;
          end else if (accept) begin
            load_ifid  = 1'b1;
            load_instr = imem_rdata;
            load_pc    = addr_q;
            pc_d       = addr_q + 64'd4;
            addr_d     = addr_q + 64'd4;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = addr_q;
            pc_d         = addr_q + 64'd4;
          end
        end else if (flush) begin
          // Address stays on the bus until memory answers; only the redirect is remembered.
          pc_d = branch_target;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d         = branch_target;
          addr_d       = branch_target;
          skid_instr_d = '0;
          skid_pc_d    = '0;
        end else if (!stall) begin
          load_ifid  = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          addr_d     = pc_q;
        end
      end
      S_DRAIN: begin
        // A newer flush while draining replaces the pending redirect target.
        pc_d = drain_pc;
        if (ack)
          addr_d = drain_pc;
      end
      default: begin
        pc_d   = RESET_PC;
        addr_d = RESET_PC;
      end
    endcase
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end else if (load_ifid) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = load_instr;
      ifid_pc_d    = load_pc;
    end else if (accept) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_comb begin
    imem_req   = (state_q != S_HOLD);
    imem_addr  = addr_q;
    ifid_valid = ifid_valid_q;
    ifid_instr = ifid_instr_q;
    ifid_pc    = ifid_pc_q;
  end

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: random-latency memory, random stall/flush, and an in-order
// instruction-stream reference model (sequential PCs, restarting at each flush target).
module tb_fetch_ifid;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [63:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;

  fetch_ifid #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int n_consumed = 0;

  // Stream model: next PC decode must receive.
  logic [63:0] exp_pc;
  bit          prev_flush;
  bit          prev_hold;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;

  // Memory model.
  bit          pending;
  int          cnt;
  logic [63:0] pend_addr;
  int          lat_lo;
  int          lat_hi;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ a[63:32];
  endfunction

  task automatic model_reset();
    exp_pc     = RST_PC;
    prev_flush = 1'b0;
    prev_hold  = 1'b0;
    pending    = 1'b0;
    cnt        = 0;
  endtask

  // Called at a negedge: score what decode takes at the coming edge, drive inputs,
  // then step to the next negedge and check the post-edge state.
  task automatic cycle(input bit s, input bit f, input logic [63:0] t);
    stall         = s;
    flush         = f;
    branch_target = t;
    if (f) begin
      exp_pc = t;
    end else if (ifid_valid && !s) begin
      n_checks++;
      if (ifid_pc !== exp_pc) begin
        n_fails++;
        $display("FAIL stream_pc: got %h expected %h", ifid_pc, exp_pc);
      end
      n_checks++;
      if (ifid_instr !== word_at(exp_pc)) begin
        n_fails++;
        $display("FAIL stream_instr: got %h expected %h", ifid_instr, word_at(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
      n_consumed++;
    end
    prev_flush = f;
    prev_hold  = ifid_valid && s && !f;
    hold_pc    = ifid_pc;
    hold_instr = ifid_instr;

    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        cnt       = $urandom_range(lat_hi, lat_lo);
      end
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(pend_addr);
        pending    = 1'b0;
      end else begin
        cnt--;
      end
    end

    @(negedge clk);

    if (prev_flush) begin
      n_checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
        n_fails++;
        $display("FAIL flush_bubble: got valid=%b instr=%h expected valid=0 instr=0", ifid_valid, ifid_instr);
      end
    end
    if (prev_hold) begin
      n_checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== hold_pc || ifid_instr !== hold_instr) begin
        n_fails++;
        $display("FAIL stall_hold: got %b/%h/%h expected 1/%h/%h", ifid_valid, ifid_pc, ifid_instr, hold_pc, hold_instr);
      end
    end
    if (pending) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
        n_fails++;
        $display("FAIL addr_stable: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, pend_addr);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 64'h0) begin
      n_fails++;
      $display("FAIL %s_ifid: got %b/%h/%h expected 0/0/0", tag, ifid_valid, ifid_instr, ifid_pc);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fails++;
      $display("FAIL %s_imem: got req=%b addr=%h expected req=1 addr=%h", tag, imem_req, imem_addr, RST_PC);
    end
  endtask

  // Run until IF/ID is valid with no request outstanding, then stall one cycle to fill the skid.
  task automatic enter_hold();
    int budget = 30;
    while (!(ifid_valid && !pending) && budget > 0) begin
      cycle(1'b0, 1'b0, 64'h0);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fails++;
      $display("FAIL hold_setup_timeout: got no valid idle state expected within 30 cycles");
    end
    cycle(1'b1, 1'b0, 64'h0);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL hold_req: got %b expected 0", imem_req);
    end
  endtask

  task automatic wait_valid_at(input logic [63:0] pc, input string tag);
    int budget = 20;
    while (!ifid_valid && budget > 0) begin
      cycle(1'b0, 1'b0, 64'h0);
      budget--;
    end
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== pc) begin
      n_fails++;
      $display("FAIL %s: got valid=%b pc=%h expected valid=1 pc=%h", tag, ifid_valid, ifid_pc, pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    lat_lo = 0; lat_hi = 0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== RST_PC + 64'(4 * i)) begin
        n_fails++;
        $display("FAIL stream_seq%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, ifid_valid, ifid_pc, RST_PC + 64'(4 * i));
      end
    end
  endtask

  task automatic test_latency();
    int c0 = n_consumed;
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 64'h0);
    n_checks++;
    if (n_consumed - c0 < 3 || n_consumed - c0 > 4) begin
      n_fails++;
      $display("FAIL latency_rate: got %0d instrs expected 3..4", n_consumed - c0);
    end
  endtask

  task automatic test_stall_skid();
    int budget = 30;
    lat_lo = 0; lat_hi = 0;
    cycle(1'b0, 1'b1, 64'h0);
    while (!(ifid_valid && ifid_pc == 64'h8 && !pending) && budget > 0) begin
      cycle(1'b0, 1'b0, 64'h0);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fails++;
      $display("FAIL skid_setup_timeout: got pc=%h expected 8", ifid_pc);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 64'h0);
      n_checks++;
      if (imem_req !== 1'b0 || ifid_pc !== 64'h8) begin
        n_fails++;
        $display("FAIL skid_stall%0d: got req=%b pc=%h expected req=0 pc=8", i, imem_req, ifid_pc);
      end
    end
    cycle(1'b0, 1'b0, 64'h0);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 64'hC) begin
      n_fails++;
      $display("FAIL skid_release: got valid=%b pc=%h expected valid=1 pc=c", ifid_valid, ifid_pc);
    end
    cycle(1'b0, 1'b0, 64'h0);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 64'h10) begin
      n_fails++;
      $display("FAIL skid_next: got valid=%b pc=%h expected valid=1 pc=10", ifid_valid, ifid_pc);
    end
  endtask

  task automatic test_flush_drain();
    int budget = 10;
    lat_lo = 3; lat_hi = 3;
    cycle(1'b0, 1'b1, 64'h20);
    while (!(pending && pend_addr == 64'h20 && cnt >= 1) && budget > 0) begin
      cycle(1'b0, 1'b0, 64'h0);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fails++;
      $display("FAIL drain_setup_timeout: got addr=%h expected 20 outstanding", imem_addr);
    end
    cycle(1'b0, 1'b1, 64'h400);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h20) begin
      n_fails++;
      $display("FAIL drain_req: got req=%b addr=%h expected req=1 addr=20", imem_req, imem_addr);
    end
    wait_valid_at(64'h400, "drain_target");
  endtask

  task automatic test_flush_stall_skid();
    lat_lo = 0; lat_hi = 0;
    enter_hold();
    cycle(1'b1, 1'b1, 64'h400);
    n_checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h400) begin
      n_fails++;
      $display("FAIL flush_hold: got valid=%b req=%b addr=%h expected 0/1/400", ifid_valid, imem_req, imem_addr);
    end
    wait_valid_at(64'h400, "flush_hold_target");
  endtask

  task automatic test_wrap();
    int  budget = 12;
    bit  found = 1'b0;
    lat_lo = 0; lat_hi = 1;
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    while (!found && budget > 0) begin
      cycle(1'b0, 1'b0, 64'h0);
      found = ifid_valid && (ifid_pc == 64'h0);
      budget--;
    end
    n_checks++;
    if (!found) begin
      n_fails++;
      $display("FAIL pc_wrap: got pc=%h expected 0 after ffff_fffc", ifid_pc);
    end
  endtask

  task automatic test_reset_mid_hold();
    lat_lo = 0; lat_hi = 0;
    enter_hold();
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 64'h0);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== RST_PC) begin
      n_fails++;
      $display("FAIL restart: got valid=%b pc=%h expected valid=1 pc=%h", ifid_valid, ifid_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    int c0 = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      lat_lo = 0;
      lat_hi = 3;
      cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5,
            {$urandom, $urandom} & ~64'h3);
    end
    n_checks++;
    if (n_consumed - c0 < 300) begin
      n_fails++;
      $display("FAIL random_progress: got %0d instrs expected at least 300", n_consumed - c0);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_latency();
    test_stall_skid();
    test_flush_drain();
    test_flush_stall_skid();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
